// File: rtl/periph_bus_arbiter.sv
`timescale 1ns/1ps
// Two-master round-robin arbiter that serialises single-word transactions onto the timer bridge.
// Build option PERIPH_ARB_LOCK_EN adds m0_lock/m1_lock so an owner can keep the bus across transactions.
module periph_bus_arbiter #(
    parameter logic [31:0] TC0_BASE    = 32'h0000_7f00,
    parameter logic [31:0] TC1_BASE    = 32'h0000_7f10,
    parameter int unsigned TC_SPAN     = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rd,
`ifdef PERIPH_ARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    output logic        br_we,
    output logic        [31:0] br_addr,
    output logic [31:0] br_wd,
    input  logic [31:0] br_in,
    output logic [1:0]  dbg_state
);

    // Handshake: a master holds req/we/addr/wd stable until its one-cycle ack and drops req
    // on the edge ending that ack; req still high in the following IDLE cycle is a new transaction.
    localparam logic [31:0] TC0_LAST  = TC0_BASE + TC_SPAN - 32'd1;
    localparam logic [31:0] TC1_LAST  = TC1_BASE + TC_SPAN - 32'd1;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        lock_q, lock_d;
    logic        we_q, we_d;
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] m0_rd_q, m0_rd_d;
    logic [31:0] m1_rd_q, m1_rd_d;

    logic        lock0, lock1;
    logic        owner_req, start, pick;
    logic        sel_we;
    logic [31:0] sel_addr, sel_wd;

`ifdef PERIPH_ARB_LOCK_EN
    assign lock0 = m0_lock;
    assign lock1 = m1_lock;
`else
    assign lock0 = 1'b0;
    assign lock1 = 1'b0;
`endif

    function automatic logic in_windows(input logic [31:0] a);
        return ((a >= TC0_BASE) && (a <= TC0_LAST)) || ((a >= TC1_BASE) && (a <= TC1_LAST));
    endfunction

    assign owner_req = owner_q ? m1_req : m0_req;
    assign start     = (state_q == S_IDLE) && (m0_req || m1_req);

    // A held lock beats round-robin only while the locked owner keeps requesting.
    always_comb begin
        if (lock_q && owner_req) begin
            pick = owner_q;
        end else if (m0_req && m1_req) begin
            pick = ~last_grant_q;
        end else begin
            pick = m1_req;
        end
        sel_we   = pick ? m1_we   : m0_we;
        sel_addr = pick ? m1_addr : m0_addr;
        sel_wd   = pick ? m1_wd   : m0_wd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        we_d         = we_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        wd_d         = wd_q;
        m0_rd_d      = m0_rd_q;
        m1_rd_d      = m1_rd_q;
        case (state_q)
            S_IDLE: begin
                if (lock_q && !owner_req) begin
                    lock_d = 1'b0;
                end
                if (start) begin
                    owner_d = pick;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wd_d    = sel_wd;
                    valid_d = in_windows(sel_addr);
                end
            end
            S_ACCESS: begin
                if (owner_q) begin
                    m1_rd_d = valid_q ? br_in : 32'd0;
                end else begin
                    m0_rd_d = valid_q ? br_in : 32'd0;
                end
            end
            S_RESP: begin
                last_grant_d = owner_q;
                lock_d       = owner_q ? lock1 : lock0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lock_q       <= 1'b0;
            we_q         <= 1'b0;
            valid_q      <= 1'b0;
            addr_q       <= 32'd0;
            wd_q         <= 32'd0;
            m0_rd_q      <= 32'd0;
            m1_rd_q      <= 32'd0;
        end else begin
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            we_q         <= we_d;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            wd_q         <= wd_d;
            m0_rd_q      <= m0_rd_d;
            m1_rd_q      <= m1_rd_d;
        end
    end

    always_comb begin
        br_we     = (state_q == S_ACCESS) && we_q && valid_q;
        br_addr   = addr_q;
        br_wd     = wd_q;
        m0_ack    = (state_q == S_RESP) && !owner_q;
        m1_ack    = (state_q == S_RESP) && owner_q;
        m0_err    = m0_ack && !valid_q;
        m1_err    = m1_ack && !valid_q;
        m0_rd     = m0_rd_q;
        m1_rd     = m1_rd_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
`timescale 1ns/1ps
// Bench for periph_bus_arbiter: two instances (no wait states / three wait states), each with
// a small timer-register slave, checked every cycle against a transaction-level model.
module tb_periph_bus_arbiter;

  localparam logic [31:0] INIT [6] = '{32'hA000_0000, 32'hA000_0004, 32'hA000_0008,
                                       32'hB000_0010, 32'h1234_5678, 32'hB000_0018};
  localparam int WC [2] = '{0, 3};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_s   [2][2];
  logic        we_s    [2][2];
  logic [31:0] addr_s  [2][2];
  logic [31:0] wd_s    [2][2];
  wire         ack_s   [2][2];
  wire         err_s   [2][2];
  wire  [31:0] rd_s    [2][2];
  wire         br_we_s [2];
  wire  [31:0] br_addr_s [2];
  wire  [31:0] br_wd_s [2];
  wire  [1:0]  dbg_s   [2];
`ifdef PERIPH_ARB_LOCK_EN
  logic        lock_s  [2][2];
`endif

  int checks = 0;
  int errors = 0;

  function automatic int widx(input logic [31:0] a);
    if (a >= 32'h7f00 && a <= 32'h7f0b) return int'((a - 32'h7f00) >> 2);
    if (a >= 32'h7f10 && a <= 32'h7f1b) return 3 + int'((a - 32'h7f10) >> 2);
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_dut
    logic [31:0] br_in;
    logic [31:0] mem [6] = INIT;
    int          ix;

    periph_bus_arbiter #(.WAIT_CYCLES((d == 0) ? 0 : 3)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .m0_req   (req_s[d][0]),
      .m0_we    (we_s[d][0]),
      .m0_addr  (addr_s[d][0]),
      .m0_wd    (wd_s[d][0]),
      .m0_ack   (ack_s[d][0]),
      .m0_err   (err_s[d][0]),
      .m0_rd    (rd_s[d][0]),
      .m1_req   (req_s[d][1]),
      .m1_we    (we_s[d][1]),
      .m1_addr  (addr_s[d][1]),
      .m1_wd    (wd_s[d][1]),
      .m1_ack   (ack_s[d][1]),
      .m1_err   (err_s[d][1]),
      .m1_rd    (rd_s[d][1]),
`ifdef PERIPH_ARB_LOCK_EN
      .m0_lock  (lock_s[d][0]),
      .m1_lock  (lock_s[d][1]),
`endif
      .br_we    (br_we_s[d]),
      .br_addr  (br_addr_s[d]),
      .br_wd    (br_wd_s[d]),
      .br_in    (br_in),
      .dbg_state(dbg_s[d])
    );

    always_comb begin
      ix = widx(br_addr_s[d]);
      br_in = 32'hDEAD_BEEF;
      if (ix >= 0) br_in = mem[3'(ix)];
    end

    always @(posedge clk) begin
      if (br_we_s[d] && ix >= 0) mem[3'(ix)] <= br_wd_s[d];
    end
  end

  // Transaction-level model: one outstanding transaction per arbiter, scheduled by cycle number.
  int          cyc = 0;
  int          free_at [2], acc_at [2], ack_at [2];
  logic        own [2], lg [2], t_we [2], t_val [2], locked [2];
  logic [31:0] t_addr [2], t_wd [2], t_rd [2];
  logic [31:0] e_rd [2][2];
  logic [31:0] mmem [2][6];

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 6; i++) mmem[d][i] = INIT[i];
  end

  always @(negedge clk) begin : model
    int   ix;
    logic mm;
    logic ea;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        free_at[d] = 0; acc_at[d] = -1; ack_at[d] = -1;
        lg[d] = 1'b1; own[d] = 1'b0; t_we[d] = 1'b0; t_val[d] = 1'b0; locked[d] = 1'b0;
        t_addr[d] = '0; t_wd[d] = '0; t_rd[d] = '0; e_rd[d][0] = '0; e_rd[d][1] = '0;
      end
      for (int m = 0; m < 2; m++)
        if (cyc == ack_at[d] && int'(own[d]) == m) e_rd[d][m] = t_rd[d];
      chk($sformatf("d%0d br_we", d), 32'(br_we_s[d]), 32'(cyc == acc_at[d] && t_we[d] && t_val[d]));
      chk($sformatf("d%0d br_addr", d), br_addr_s[d], t_addr[d]);
      chk($sformatf("d%0d br_wd", d), br_wd_s[d], t_wd[d]);
      for (int m = 0; m < 2; m++) begin
        ea = (cyc == ack_at[d]) && (int'(own[d]) == m);
        chk($sformatf("d%0d m%0d_ack", d, m), 32'(ack_s[d][m]), 32'(ea));
        chk($sformatf("d%0d m%0d_err", d, m), 32'(err_s[d][m]), 32'(ea && !t_val[d]));
        chk($sformatf("d%0d m%0d_rd", d, m), rd_s[d][m], e_rd[d][m]);
      end
      if (reset) begin
        if (cyc == acc_at[d]) begin
          ix = widx(t_addr[d]);
          t_rd[d] = (ix >= 0) ? mmem[d][3'(ix)] : 32'd0;
          if (ix >= 0 && t_we[d]) mmem[d][3'(ix)] = t_wd[d];
        end
`ifdef PERIPH_ARB_LOCK_EN
        if (cyc == ack_at[d]) locked[d] = lock_s[d][own[d]];
`endif
        if (cyc >= free_at[d]) begin
          if (locked[d] && !req_s[d][own[d]]) locked[d] = 1'b0;
          if (req_s[d][0] || req_s[d][1]) begin
            if (locked[d]) mm = own[d];
            else if (req_s[d][0] && req_s[d][1]) mm = ~lg[d];
            else mm = req_s[d][1];
            own[d] = mm; lg[d] = mm;
            t_we[d] = we_s[d][mm]; t_addr[d] = addr_s[d][mm]; t_wd[d] = wd_s[d][mm];
            t_val[d] = widx(addr_s[d][mm]) >= 0;
            acc_at[d] = cyc + 1 + WC[d];
            ack_at[d] = cyc + 2 + WC[d];
            free_at[d] = cyc + 3 + WC[d];
          end
        end
      end
    end
  end

  task automatic txn(input int d, input int m, input logic w, input logic [31:0] a, input logic [31:0] v,
                     output int lat, output logic [31:0] r, output logic e, output int nwe,
                     output int wk, output logic [31:0] wa);
    bit done;
    done = 1'b0;
    req_s[d][m] = 1'b1; we_s[d][m] = w; addr_s[d][m] = a; wd_s[d][m] = v;
    lat = -1; r = '0; e = 1'b0; nwe = 0; wk = -1; wa = '0;
    for (int k = 0; k < 24 && !done; k++) begin
      @(negedge clk);
      if (br_we_s[d]) begin
        nwe++;
        if (wk < 0) begin wk = k; wa = br_addr_s[d]; end
      end
      if (ack_s[d][m]) begin done = 1'b1; lat = k; r = rd_s[d][m]; e = err_s[d][m]; end
    end
    if (!done) chk("txn_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_s[d][m] = 1'b0; we_s[d][m] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  logic [31:0] tbl_addr [7] = '{32'h7eff, 32'h7f00, 32'h7f0b, 32'h7f0f, 32'h7f10, 32'h7f1b, 32'h7f1c};
  logic        tbl_err  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int          lat, nwe, wk, n, kk;
    logic [31:0] r, wa;
    logic        e;
    int          ord [4];
    int          at [4];
    bit          stop;
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) begin
        req_s[d][m] = 1'b0; we_s[d][m] = 1'b0; addr_s[d][m] = '0; wd_s[d][m] = '0;
`ifdef PERIPH_ARB_LOCK_EN
        lock_s[d][m] = 1'b0;
`endif
      end
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_m0_ack", 32'(ack_s[0][0]), 32'd0);
    chk("rst_m1_rd", rd_s[0][1], 32'd0);
    chk("rst_br_addr", br_addr_s[1], 32'd0);
    chk("rst_state", 32'(dbg_s[0]), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // M0 write 0x7f04 <- 0xff: one br_we at req+1, ack at req+2, old register value returned.
    txn(0, 0, 1'b1, 32'h7f04, 32'h0000_00ff, lat, r, e, nwe, wk, wa);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_err", 32'(e), 32'd0);
    chk("wr_nwe", 32'(nwe), 32'd1);
    chk("wr_we_cycle", 32'(wk), 32'd1);
    chk("wr_we_addr", wa, 32'h7f04);
    chk("wr_rd_old", r, 32'hA000_0004);
    chk("wr_mem", g_dut[0].mem[1], 32'h0000_00ff);

    txn(0, 1, 1'b0, 32'h7f14, 32'd0, lat, r, e, nwe, wk, wa);
    chk("rd_lat", 32'(lat), 32'd2);
    chk("rd_data", r, 32'h1234_5678);
    chk("rd_err", 32'(e), 32'd0);

    // Gap address: no write, err, zero data.
    txn(0, 0, 1'b1, 32'h7f0c, 32'h5555_5555, lat, r, e, nwe, wk, wa);
    chk("gap_nwe", 32'(nwe), 32'd0);
    chk("gap_err", 32'(e), 32'd1);
    chk("gap_rd", r, 32'd0);

    // Window boundaries: write then read back.
    for (int i = 0; i < 7; i++) begin
      txn(0, i % 2, 1'b1, tbl_addr[i], 32'hC0DE_0000 | 32'(i), lat, r, e, nwe, wk, wa);
      chk($sformatf("bnd%0d_wr_err", i), 32'(e), 32'(tbl_err[i]));
      txn(0, (i + 1) % 2, 1'b0, tbl_addr[i], 32'd0, lat, r, e, nwe, wk, wa);
      chk($sformatf("bnd%0d_rd", i), r, tbl_err[i] ? 32'd0 : (32'hC0DE_0000 | 32'(i)));
    end

    // Both masters requesting continuously from reset: strict alternation, 3 cycles apart.
    pulse_reset();
    req_s[0][0] = 1'b1; addr_s[0][0] = 32'h7f00;
    req_s[0][1] = 1'b1; addr_s[0][1] = 32'h7f18;
    n = 0;
    for (int k = 0; k < 30 && n < 4; k++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++)
        if (ack_s[0][m] && n < 4) begin ord[n] = m; at[n] = k; n++; end
    end
    @(posedge clk); #1 req_s[0][0] = 1'b0; req_s[0][1] = 1'b0;
    chk("rr_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 32'(ord[i]), 32'(i % 2));
    chk("rr_first", 32'(at[0]), 32'd2);
    for (int i = 1; i < 4; i++) chk($sformatf("rr_gap%0d", i), 32'(at[i] - at[i-1]), 32'd3);

    // Three wait states: ack at req+5.
    txn(1, 1, 1'b0, 32'h7f14, 32'd0, lat, r, e, nwe, wk, wa);
    chk("ws_lat", 32'(lat), 32'd5);
    chk("ws_rd", r, 32'h1234_5678);

    // Reset during WAIT aborts a write: no ack, no br_we, outputs cleared.
    req_s[1][1] = 1'b1; we_s[1][1] = 1'b1; addr_s[1][1] = 32'h7f08; wd_s[1][1] = 32'h9999_9999;
    @(posedge clk); #2 reset = 1'b0;
    req_s[1][1] = 1'b0; we_s[1][1] = 1'b0;
    @(negedge clk);
    chk("abort_rd", rd_s[1][1], 32'd0);
    chk("abort_state", 32'(dbg_s[1]), 32'd0);
    chk("abort_br_addr", br_addr_s[1], 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    nwe = 0; n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (br_we_s[1]) nwe++;
      if (ack_s[1][1]) n++;
    end
    chk("abort_nwe", 32'(nwe), 32'd0);
    chk("abort_ack", 32'(n), 32'd0);
    chk("abort_mem", g_dut[1].mem[2], 32'hA000_0008);

`ifdef PERIPH_ARB_LOCK_EN
    // M0 locks across two back-to-back transactions while M1 waits.
    pulse_reset();
    lock_s[0][0] = 1'b1;
    req_s[0][0] = 1'b1; addr_s[0][0] = 32'h7f00;
    req_s[0][1] = 1'b1; addr_s[0][1] = 32'h7f10;
    n = 0; kk = 0; stop = 1'b0;
    for (int k = 0; k < 40 && !stop; k++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++)
        if (ack_s[0][m] && n < 3) begin ord[n] = m; n++; if (m == 0) kk++; end
      if (n == 3) stop = 1'b1;
      if (kk == 2 && req_s[0][0]) begin
        @(posedge clk); #1 req_s[0][0] = 1'b0; lock_s[0][0] = 1'b0;
      end
    end
    @(posedge clk); #1 req_s[0][1] = 1'b0;
    chk("lock_count", 32'(n), 32'd3);
    chk("lock_order0", 32'(ord[0]), 32'd0);
    chk("lock_order1", 32'(ord[1]), 32'd0);
    chk("lock_order2", 32'(ord[2]), 32'd1);
`endif

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
